mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of the EX stage.
- Consumes EX's registered pipeline bus and memory-control bus, and runs loads/stores on a valid/grant data-memory port.
- Formats load data, stalls the pipeline while an access is outstanding, and registers the result bus for WB.
- Drives the MEM bypass bus back to EX forwarding.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in WAIT_RSP before a bus error is declared; legal range 1..65535.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- ex_bus_i  in  core::pipeline_bus_t  EX→MEM bus; uses mem_op, rd addr, rd_res, reg-write enable
- ex2mem_i  in  core::mem_cntrl_bus_t  addr[31:0], wdata[31:0]; all-zero when mem_op==MEM_NOP
- dmem_req_o  out  1  request valid
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  32  word-aligned address, {addr[31:2],2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  load data valid
- dmem_rdata_i  in  32  load data word
- stall_o  out  1  freeze IF/ID/EX; ex_bus_i/ex2mem_i held stable while high
- mem_bypass_o  out  core::bypass_bus_t  forwarding source for EX
- mem_bus_o  out  core::pipeline_bus_t  registered MEM→WB bus
- misalign_o  out  1  one-cycle pulse: misaligned access dropped
- bus_err_o  out  1  one-cycle pulse: load response timeout

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, timeout counter=0.
  - mem_bus_o=NOP: data bits 0, mem_op=MEM_NOP, alu_op=ALU_NOP, format=NOP, instr=riscv::I_NOP.
  - dmem_req_o=0, stall_o=0, misalign_o=0, bus_err_o=0.
- Reset mid-access: abandon the transaction. Any rvalid arriving later in IDLE is ignored.
- Non-memory instruction: mem_bus_o<=ex_bus_i next edge (1-cycle latency), no stall.
- Misalignment rules:
  - LH/LHU/SH misaligned when addr[0]=1.
  - LW/SW misaligned when addr[1:0]!=0.
  - On misalignment: no request, misalign_o pulses next cycle, and the instruction passes to WB with reg-write cleared and rd_res=0.
- FSM states IDLE, REQ, WAIT_RSP.
  - IDLE, aligned mem op present: dmem_req_o=1 combinationally.
    - gnt=0 → REQ.
    - gnt=1 with store → done this cycle.
    - gnt=1 with load and rvalid=1 in the same cycle → done.
    - gnt=1 with load, no rvalid → WAIT_RSP.
  - REQ: req held with addr/we/be/wdata stable until gnt; same exits as IDLE.
  - WAIT_RSP: req=0; counter increments each cycle.
    - rvalid → done, back to IDLE.
    - counter==TIMEOUT_CYCLES-1 without rvalid → done with rd_res=0 and reg-write cleared; bus_err_o pulses; back to IDLE.
- stall_o = aligned mem op present AND not done this cycle.
- On done: mem_bus_o captures ex_bus_i with rd_res replaced by formatted load data (loads). While stalled, mem_bus_o<=NOP bubble.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=4'b0011<<addr[1:0], wdata={2{wdata[15:0]}}.
  - SW: be=4'b1111.
- Loads: select byte/half by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word.
- mem_bypass_o: valid when ex_bus_i writes rd, rd!=0, and it is not a load; data=ex_bus_i.rd_res. Loads are never bypassed from MEM; the load-use stall belongs to the hazard unit.
- A spurious rvalid in IDLE/REQ is ignored. A gnt without req is ignored.

Decomposition:
- Add to package core:
  - mem_state_t enum {IDLE, REQ, WAIT_RSP}.
  - Helpers is_load(mem_op), is_store(mem_op), mem_size(mem_op).
  - DMEM_BE_W=4.
- One sub-module, lsu_align: combinational store lane/byte-enable generation, load extract/extend, and misalignment check. The FSM, counter and pipeline register stay in mem_stage.

Test Plan:
- ADD rd=5 rd_res=0x1234, no memory → mem_bus_o.rd_res=0x1234 one cycle later; stall_o never high; mem_bypass_o valid rd=5.
- SB addr=0x1003 wdata=0xAB, gnt same cycle → be=4'b1000, wdata=0xABABABAB, addr=0x1000; no stall.
- LH addr=0x2002, gnt cycle 0, rvalid cycle 2 rdata=0x8001_0000 → stall_o high cycles 0-1; rd_res=0xFFFF8001. LHU variant → 0x00008001.
- LW addr=0x3001 → no dmem_req_o; misalign_o pulse; WB sees reg-write=0.
- TIMEOUT_CYCLES=4, LW granted, no rvalid → bus_err_o pulses after 4 WAIT_RSP cycles; stall_o drops; rd_res=0.
- rst asserted in WAIT_RSP, then rvalid → state IDLE, outputs at reset values, rvalid ignored, mem_bus_o stays NOP.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Packages: riscv, core
// Shared pipeline types plus the MEM-stage helpers (state enum, access decode).
// Revision: 1.0
// ----------------------------------------------------------------------------
package riscv;
  typedef logic [31:0] instr_t;
  localparam instr_t I_NOP = 32'h0000_0013;  // addi x0, x0, 0
endpackage

package core;
  typedef enum logic [3:0] {
    MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_t;

  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;

  typedef enum logic [2:0] {
    NOP, R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE
  } format_t;

  typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W} mem_size_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} mem_state_t;

  localparam int DMEM_BE_W = 4;

  typedef struct packed {
    logic [31:0]    pc;
    riscv::instr_t  instr;
    format_t        format;
    alu_op_t        alu_op;
    mem_op_t        mem_op;
    logic           rd_we;
    logic [4:0]     rd_addr;
    logic [31:0]    rd_res;
  } pipeline_bus_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cntrl_bus_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd_addr;
    logic [31:0] data;
  } bypass_bus_t;

  localparam pipeline_bus_t PIPE_NOP = '{
    pc:      32'h0,
    instr:   riscv::I_NOP,
    format:  NOP,
    alu_op:  ALU_NOP,
    mem_op:  MEM_NOP,
    rd_we:   1'b0,
    rd_addr: 5'h0,
    rd_res:  32'h0
  };

  function automatic logic is_load(input mem_op_t op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic mem_size_t mem_size(input mem_op_t op);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return SIZE_H;
      MEM_LW, MEM_SW:          return SIZE_W;
      default:                 return SIZE_B;
    endcase
  endfunction
endpackage
`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module: lsu_align
// Store lane replication / byte enables, load extract + extend, misalign check.
// Revision: 1.0
// ----------------------------------------------------------------------------
module lsu_align
  import core::*;
(
  input  mem_op_t               mem_op_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  input  logic [31:0]           rdata_i,
  output logic [DMEM_BE_W-1:0]  be_o,
  output logic [31:0]           wdata_o,
  output logic [31:0]           rdata_o,
  output logic                  misalign_o
);

  mem_size_t   size;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_mem;

  always_comb begin
    size       = mem_size(mem_op_i);
    is_mem     = is_load(mem_op_i) || is_store(mem_op_i);
    be_o       = '0;
    wdata_o    = '0;
    rdata_o    = '0;
    misalign_o = 1'b0;

    case (addr_i[1:0])
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    if (is_mem) begin
      case (size)
        SIZE_H:  misalign_o = addr_i[0];
        SIZE_W:  misalign_o = (addr_i[1:0] != 2'b00);
        default: misalign_o = 1'b0;
      endcase
    end

    if (is_store(mem_op_i)) begin
      case (size)
        SIZE_B: begin
          be_o    = 4'b0001 << addr_i[1:0];
          wdata_o = {4{wdata_i[7:0]}};
        end
        SIZE_H: begin
          be_o    = 4'b0011 << addr_i[1:0];
          wdata_o = {2{wdata_i[15:0]}};
        end
        default: begin
          be_o    = 4'b1111;
          wdata_o = wdata_i;
        end
      endcase
    end

    case (mem_op_i)
      MEM_LB:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: rdata_o = {24'h0, byte_sel};
      MEM_LH:  rdata_o = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: rdata_o = {16'h0, half_sel};
      MEM_LW:  rdata_o = rdata_i;
      default: rdata_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module: mem_stage
// Pipeline MEM stage: drives the valid/grant data port, stalls while an access
// is outstanding and registers the result bus for WB.
// Revision: 1.0
// ----------------------------------------------------------------------------
module mem_stage
  import core::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  pipeline_bus_t         ex_bus_i,
  input  mem_cntrl_bus_t        ex2mem_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [31:0]           dmem_addr_o,
  output logic [DMEM_BE_W-1:0]  dmem_be_o,
  output logic [31:0]           dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [31:0]           dmem_rdata_i,
  output logic                  stall_o,
  output bypass_bus_t           mem_bypass_o,
  output pipeline_bus_t         mem_bus_o,
  output logic                  misalign_o,
  output logic                  bus_err_o
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  mem_state_t    state_q, state_d;
  logic [15:0]   tmo_cnt_q, tmo_cnt_d;
  pipeline_bus_t mem_bus_q, mem_bus_d;
  logic          misalign_q, misalign_d;
  logic          bus_err_q, bus_err_d;

  logic [DMEM_BE_W-1:0] lsu_be;
  logic [31:0]          lsu_wdata;
  logic [31:0]          lsu_rdata;
  logic                 lsu_misalign;

  logic op_load, op_store, aligned_op, done, timeout, req;

  lsu_align u_lsu_align (
    .mem_op_i   (ex_bus_i.mem_op),
    .addr_i     (ex2mem_i.addr),
    .wdata_i    (ex2mem_i.wdata),
    .rdata_i    (dmem_rdata_i),
    .be_o       (lsu_be),
    .wdata_o    (lsu_wdata),
    .rdata_o    (lsu_rdata),
    .misalign_o (lsu_misalign)
  );

  assign op_load    = is_load(ex_bus_i.mem_op);
  assign op_store   = is_store(ex_bus_i.mem_op);
  assign aligned_op = (op_load || op_store) && !lsu_misalign;

  // Access FSM: IDLE and REQ share exits; only WAIT_RSP runs the timeout.
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    req       = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;

    case (state_q)
      IDLE, REQ: begin
        tmo_cnt_d = '0;
        if (aligned_op) begin
          req = 1'b1;
          if (!dmem_gnt_i) begin
            state_d = REQ;
          end else if (op_store || dmem_rvalid_i) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_RSP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_RSP: begin
        tmo_cnt_d = tmo_cnt_q + 16'd1;
        if (dmem_rvalid_i) begin
          done      = 1'b1;
          state_d   = IDLE;
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TIMEOUT_LAST) begin
          done      = 1'b1;
          timeout   = 1'b1;
          state_d   = IDLE;
          tmo_cnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        tmo_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    mem_bus_d  = ex_bus_i;
    misalign_d = lsu_misalign;
    bus_err_d  = timeout;

    if (lsu_misalign) begin
      mem_bus_d.rd_we  = 1'b0;
      mem_bus_d.rd_res = '0;
    end else if (aligned_op) begin
      if (!done) begin
        mem_bus_d = PIPE_NOP;
      end else if (op_load) begin
        if (timeout) begin
          mem_bus_d.rd_we  = 1'b0;
          mem_bus_d.rd_res = '0;
        end else begin
          mem_bus_d.rd_res = lsu_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tmo_cnt_q  <= '0;
      mem_bus_q  <= PIPE_NOP;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      mem_bus_q  <= mem_bus_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Loads are never forwarded from here; load-use is the hazard unit's job.
  always_comb begin
    mem_bypass_o         = '0;
    mem_bypass_o.valid   = ex_bus_i.rd_we && (ex_bus_i.rd_addr != 5'd0) && !op_load;
    mem_bypass_o.rd_addr = ex_bus_i.rd_addr;
    mem_bypass_o.data    = ex_bus_i.rd_res;
  end

  assign dmem_req_o   = req;
  assign dmem_we_o    = op_store;
  assign dmem_addr_o  = {ex2mem_i.addr[31:2], 2'b00};
  assign dmem_be_o    = lsu_be;
  assign dmem_wdata_o = lsu_wdata;
  assign stall_o      = aligned_op && !done;
  assign mem_bus_o    = mem_bus_q;
  assign misalign_o   = misalign_q;
  assign bus_err_o    = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module: tb_mem_stage
// Self-checking bench: vector table, corner sequences, randomized transactions.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_mem_stage;
  import core::*;

  localparam int TO = 4;

  logic           clk = 1'b0;
  logic           rst;
  pipeline_bus_t  ex_bus;
  mem_cntrl_bus_t ex2mem;
  logic           req, we, gnt, rvalid, stall, misal, berr;
  logic [31:0]    daddr, dwdata, rdata;
  logic [3:0]     be;
  bypass_bus_t    byp;
  pipeline_bus_t  mbus;

  int errors = 0;
  int checks = 0;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_bus_i      (ex_bus),
    .ex2mem_i      (ex2mem),
    .dmem_req_o    (req),
    .dmem_we_o     (we),
    .dmem_addr_o   (daddr),
    .dmem_be_o     (be),
    .dmem_wdata_o  (dwdata),
    .dmem_gnt_i    (gnt),
    .dmem_rvalid_i (rvalid),
    .dmem_rdata_i  (rdata),
    .stall_o       (stall),
    .mem_bypass_o  (byp),
    .mem_bus_o     (mbus),
    .misalign_o    (misal),
    .bus_err_o     (berr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: access size in bytes and the architectural load/store rules.
  function automatic int m_bytes(input mem_op_t op);
    if (op inside {MEM_LB, MEM_LBU, MEM_SB}) return 1;
    if (op inside {MEM_LH, MEM_LHU, MEM_SH}) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input mem_op_t op, input logic [31:0] a);
    int m;
    m = ((1 << m_bytes(op)) - 1) << int'(a[1:0]);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input mem_op_t op, input logic [31:0] w);
    if (m_bytes(op) == 1) return {4{w[7:0]}};
    if (m_bytes(op) == 2) return {2{w[15:0]}};
    return w;
  endfunction

  function automatic logic [31:0] m_load(input mem_op_t op, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] b, h;
    b = d >> (8 * int'(a[1:0]));
    h = d >> (16 * int'(a[1]));
    case (op)
      MEM_LB:  return {{24{b[7]}}, b[7:0]};
      MEM_LBU: return {24'h0, b[7:0]};
      MEM_LH:  return {{16{h[15]}}, h[15:0]};
      MEM_LHU: return {16'h0, h[15:0]};
      default: return d;
    endcase
  endfunction

  task automatic set_in(input mem_op_t op, input logic [31:0] a, input logic [31:0] w,
                        input logic rwe, input logic [4:0] rd, input logic [31:0] res);
    ex_bus         = PIPE_NOP;
    ex_bus.pc      = 32'h0000_0100;
    ex_bus.format  = I_TYPE;
    ex_bus.alu_op  = ALU_ADD;
    ex_bus.mem_op  = op;
    ex_bus.rd_we   = rwe;
    ex_bus.rd_addr = rd;
    ex_bus.rd_res  = res;
    if (op == MEM_NOP) ex2mem = '0;
    else begin
      ex2mem.addr  = a;
      ex2mem.wdata = w;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    set_in(MEM_NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
  endtask

  // Multi-cycle transaction with grant after gd cycles and response rsp cycles later.
  task automatic run_txn(input mem_op_t op, input logic [31:0] a, input logic [31:0] w,
                         input logic [31:0] d, input int gd, input int rsp, input string nm);
    logic ld, fin;
    int   c;
    ld  = is_load(op);
    fin = 1'b0;
    c   = 0;
    while (!fin && c < 20) begin
      @(negedge clk);
      if (c == 0) set_in(op, a, w, ld, 5'd7, 32'h0);
      gnt    = (c == gd);
      rvalid = ld && ((c == gd + rsp) || (c < gd && $urandom_range(0, 1) == 1));
      rdata  = (c == gd + rsp) ? d : $urandom;
      fin    = ld ? (c == gd + rsp) : (c == gd);
      #1;
      chk({nm, " req"}, 32'(req), 32'(c <= gd));
      chk({nm, " stall"}, 32'(stall), 32'(!fin));
      if (c <= gd) begin
        chk({nm, " addr"}, daddr, a & 32'hFFFF_FFFC);
        chk({nm, " we"}, 32'(we), 32'(!ld));
        if (!ld) begin
          chk({nm, " be"}, 32'(be), 32'(m_be(op, a)));
          chk({nm, " wdata"}, dwdata, m_wdata(op, w));
        end
      end
      if (c == 0) chk({nm, " bypass"}, 32'(byp.valid), 32'(0));
      @(posedge clk); #1;
      if (fin) begin
        chk({nm, " rd_res"}, mbus.rd_res, ld ? m_load(op, a, d) : 32'h0);
        chk({nm, " rd_we"}, 32'(mbus.rd_we), 32'(ld));
        chk({nm, " mem_op"}, 32'(mbus.mem_op), 32'(op));
      end else begin
        chk({nm, " bubble"}, 32'(mbus.mem_op), 32'(MEM_NOP));
      end
      c++;
    end
    if (!fin) chk({nm, " completion"}, 32'(0), 32'(1));
    idle();
  endtask

  typedef struct {
    mem_op_t     op;
    logic [31:0] addr, wdata, rdata;
    logic        rwe;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        g, rv;
    logic        e_req;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_res;
    logic        e_we, e_mis;
  } vec_t;

  vec_t vt[10];

  initial begin
    mem_op_t ops[8];
    mem_op_t op;
    logic [31:0] a;
    ops = '{MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW};

    vt[0] = '{MEM_NOP, 32'h0,    32'h0,        32'h0,        1, 5'd5, 32'h1234, 0, 0, 0, 4'h0, 32'h0,        32'h1234,     1, 0};
    vt[1] = '{MEM_SB,  32'h1003, 32'hAB,       32'h0,        0, 5'd0, 32'h0,    1, 0, 1, 4'h8, 32'hABABABAB, 32'h0,        0, 0};
    vt[2] = '{MEM_SH,  32'h1002, 32'h1111CAFE, 32'h0,        0, 5'd0, 32'h0,    1, 0, 1, 4'hC, 32'hCAFECAFE, 32'h0,        0, 0};
    vt[3] = '{MEM_SW,  32'h1004, 32'h12345678, 32'h0,        0, 5'd0, 32'h0,    1, 0, 1, 4'hF, 32'h12345678, 32'h0,        0, 0};
    vt[4] = '{MEM_LB,  32'h2001, 32'h0,        32'h112280FF, 1, 5'd3, 32'h0,    1, 1, 1, 4'h0, 32'h0,        32'hFFFFFF80, 1, 0};
    vt[5] = '{MEM_LBU, 32'h2003, 32'h0,        32'h9A000000, 1, 5'd3, 32'h0,    1, 1, 1, 4'h0, 32'h0,        32'h0000009A, 1, 0};
    vt[6] = '{MEM_LW,  32'h2000, 32'h0,        32'hDEADBEEF, 1, 5'd4, 32'h0,    1, 1, 1, 4'h0, 32'h0,        32'hDEADBEEF, 1, 0};
    vt[7] = '{MEM_LW,  32'h3001, 32'h0,        32'h0,        1, 5'd6, 32'h55,   1, 0, 0, 4'h0, 32'h0,        32'h0,        0, 1};
    vt[8] = '{MEM_SH,  32'h3003, 32'hFFFF,     32'h0,        0, 5'd0, 32'h0,    0, 0, 0, 4'h0, 32'h0,        32'h0,        0, 1};
    vt[9] = '{MEM_LHU, 32'h2002, 32'h0,        32'h80010000, 1, 5'd2, 32'h0,    1, 1, 1, 4'h0, 32'h0,        32'h00008001, 1, 0};

    // Reset state
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    set_in(MEM_NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    #12;
    chk("rst mem_op", 32'(mbus.mem_op), 32'(MEM_NOP));
    chk("rst instr", mbus.instr, riscv::I_NOP);
    chk("rst rd_res", mbus.rd_res, 32'h0);
    chk("rst alu_op", 32'(mbus.alu_op), 32'(ALU_NOP));
    chk("rst req", 32'(req), 32'(0));
    chk("rst stall", 32'(stall), 32'(0));
    chk("rst misalign", 32'(misal), 32'(0));
    chk("rst bus_err", 32'(berr), 32'(0));
    @(negedge clk); rst = 1'b0;

    // Single-cycle vectors
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_in(vt[i].op, vt[i].addr, vt[i].wdata, vt[i].rwe, vt[i].rd, vt[i].res);
      gnt = vt[i].g; rvalid = vt[i].rv; rdata = vt[i].rdata;
      #1;
      chk($sformatf("v%0d req", i), 32'(req), 32'(vt[i].e_req));
      chk($sformatf("v%0d stall", i), 32'(stall), 32'(0));
      chk($sformatf("v%0d bypass", i), 32'(byp.valid),
          32'(vt[i].rwe && vt[i].rd != 5'd0 && !is_load(vt[i].op)));
      if (byp.valid) chk($sformatf("v%0d bypass data", i), byp.data, vt[i].res);
      if (vt[i].e_req) begin
        chk($sformatf("v%0d addr", i), daddr, vt[i].addr & 32'hFFFF_FFFC);
        if (is_store(vt[i].op)) begin
          chk($sformatf("v%0d be", i), 32'(be), 32'(vt[i].e_be));
          chk($sformatf("v%0d wdata", i), dwdata, vt[i].e_wd);
        end
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d rd_res", i), mbus.rd_res, vt[i].e_res);
      chk($sformatf("v%0d rd_we", i), 32'(mbus.rd_we), 32'(vt[i].e_we));
      chk($sformatf("v%0d mem_op", i), 32'(mbus.mem_op), 32'(vt[i].op));
      chk($sformatf("v%0d misalign", i), 32'(misal), 32'(vt[i].e_mis));
    end
    idle();

    // LH/LHU with a two-cycle response, plus a store granted late
    run_txn(MEM_LH,  32'h2002, 32'h0, 32'h80010000, 0, 2, "lh wait");
    run_txn(MEM_LHU, 32'h2002, 32'h0, 32'h80010000, 0, 2, "lhu wait");
    run_txn(MEM_SW,  32'h2008, 32'hA5A5F00D, 32'h0, 2, 0, "sw req");

    // Response timeout
    for (int c = 0; c <= TO; c++) begin
      @(negedge clk);
      if (c == 0) set_in(MEM_LW, 32'h4000, 32'h0, 1'b1, 5'd9, 32'h77);
      gnt = (c == 0); rvalid = 1'b0; rdata = $urandom;
      #1 chk($sformatf("tmo stall c%0d", c), 32'(stall), 32'(c < TO));
      @(posedge clk); #1;
      chk($sformatf("tmo bus_err c%0d", c), 32'(berr), 32'(c == TO));
      if (c == TO) begin
        chk("tmo rd_res", mbus.rd_res, 32'h0);
        chk("tmo rd_we", 32'(mbus.rd_we), 32'(0));
        chk("tmo mem_op", 32'(mbus.mem_op), 32'(MEM_LW));
      end
    end
    idle();
    @(posedge clk); #1 chk("tmo pulse end", 32'(berr), 32'(0));

    // Reset while waiting for a response, then a stray rvalid
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (c == 0) set_in(MEM_LW, 32'h5000, 32'h0, 1'b1, 5'd10, 32'h0);
      gnt = (c == 0); rvalid = 1'b0;
      #1 chk($sformatf("rstw stall c%0d", c), 32'(stall), 32'(1));
    end
    @(negedge clk);
    rst = 1'b1;
    set_in(MEM_NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    gnt = 1'b0;
    #1;
    chk("rstw req", 32'(req), 32'(0));
    chk("rstw stall", 32'(stall), 32'(0));
    chk("rstw mem_op", 32'(mbus.mem_op), 32'(MEM_NOP));
    chk("rstw instr", mbus.instr, riscv::I_NOP);
    @(negedge clk);
    rst = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_BABE;
    @(posedge clk); #1;
    chk("rstw stray rd_res", mbus.rd_res, 32'h0);
    chk("rstw stray mem_op", 32'(mbus.mem_op), 32'(MEM_NOP));
    chk("rstw stray bus_err", 32'(berr), 32'(0));
    idle();
    run_txn(MEM_LW, 32'h5004, 32'h0, 32'h0BADF00D, 0, 0, "post rst");

    // Randomized aligned transactions against the model
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 7)];
      a  = $urandom;
      a  = a & ~(32'(m_bytes(op)) - 32'd1);
      run_txn(op, a, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 3),
              $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
